// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle controller and the RV32I datapath.
// master = controller side, slave = datapath side.
interface multicycle_controller_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       zero;
  logic       lt;
  logic       mem_ready;
  logic       mem_req;
  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ImmSrc;
  logic [1:0] ALUOp;
  logic       RegWrite;
  logic       illegal;
  logic [3:0] state_o;

  modport master (
    input  op, funct3, zero, lt, mem_ready,
    output mem_req, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
           ALUSrcB, ImmSrc, ALUOp, RegWrite, illegal, state_o
  );

  modport slave (
    output op, funct3, zero, lt, mem_ready,
    input  mem_req, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
           ALUSrcB, ImmSrc, ALUOp, RegWrite, illegal, state_o
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle RV32I control FSM sharing one ALU and one memory port.
// Optional retired-instruction counter enabled by defining MC_INSTRET_EN.
module multicycle_controller #(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input logic                   clk,
    input logic                   reset,
    multicycle_controller_if.master bus
`ifdef MC_INSTRET_EN
    ,
    output logic [31:0]           instret
`endif
);

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECR    = 4'd6;
    localparam logic [3:0] S_EXECI    = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_BRANCH   = 4'd9;
    localparam logic [3:0] S_JAL      = 4'd10;
    localparam logic [3:0] S_JALR     = 4'd11;
    localparam logic [3:0] S_JALRWB   = 4'd12;
    localparam logic [3:0] S_UIMM     = 4'd13;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    logic [3:0] state, next_state;
    logic       op_legal, taken;
    logic       mem_req, adr_src, mem_write, ir_write, reg_write, pc_update, branch;
    logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
    logic [2:0] imm_src;

    // NOTE: state registers use non-blocking assignments; combinational blocks use blocking ones.
    always_ff @(posedge clk) begin
        if (!reset) state <= RESET_STATE;
        else        state <= next_state;
    end

    always_comb begin
        op_legal = 1'b1;
        case (bus.op)
            OP_LOAD, OP_STORE, OP_R, OP_I, OP_BR,
            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: op_legal = 1'b1;
            default:                          op_legal = 1'b0;
        endcase
    end

    always_comb begin
        taken = 1'b0;
        case (bus.funct3)
            3'b000:  taken = bus.zero;
            3'b001:  taken = !bus.zero;
            3'b100:  taken = bus.lt;
            3'b101:  taken = !bus.lt;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        next_state = state;
        case (state)
            S_FETCH:    if (bus.mem_ready) next_state = S_DECODE;
            S_DECODE: begin
                case (bus.op)
                    OP_LOAD, OP_STORE: next_state = S_MEMADR;
                    OP_R:              next_state = S_EXECR;
                    OP_I:              next_state = S_EXECI;
                    OP_BR:             next_state = S_BRANCH;
                    OP_JAL:            next_state = S_JAL;
                    OP_JALR:           next_state = S_JALR;
                    OP_LUI, OP_AUIPC:  next_state = S_UIMM;
                    default:           next_state = S_FETCH;
                endcase
            end
            S_MEMADR:   next_state = (bus.op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (bus.mem_ready) next_state = S_MEMWB;
            S_MEMWRITE: if (bus.mem_ready) next_state = S_FETCH;
            S_EXECR, S_EXECI, S_JAL, S_UIMM:  next_state = S_ALUWB;
            S_JALR:     next_state = S_JALRWB;
            S_MEMWB, S_ALUWB, S_BRANCH, S_JALRWB: next_state = S_FETCH;
            default:    next_state = S_FETCH;
        endcase
    end

    // NOTE: every output gets a default first, so no path through the case can infer a latch.
    always_comb begin
        mem_req = 1'b0; adr_src = 1'b0; mem_write = 1'b0; ir_write = 1'b0;
        reg_write = 1'b0; pc_update = 1'b0; branch = 1'b0;
        result_src = 2'b00; alu_src_a = 2'b00; alu_src_b = 2'b00;
        alu_op = 2'b00; imm_src = 3'b000;
        if (reset) begin
            case (state)
                S_FETCH: begin
                    mem_req = 1'b1; alu_src_b = 2'b10; result_src = 2'b10;
                    ir_write = bus.mem_ready; pc_update = bus.mem_ready;
                end
                S_DECODE: begin
                    alu_src_a = 2'b01; alu_src_b = 2'b01; imm_src = 3'b010;
                end
                S_MEMADR: begin
                    alu_src_a = 2'b10; alu_src_b = 2'b01;
                    imm_src = (bus.op == OP_STORE) ? 3'b001 : 3'b000;
                end
                S_MEMREAD:  begin mem_req = 1'b1; adr_src = 1'b1; end
                S_MEMWB:    begin result_src = 2'b01; reg_write = 1'b1; end
                S_MEMWRITE: begin mem_req = 1'b1; adr_src = 1'b1; mem_write = 1'b1; end
                S_EXECR:    begin alu_src_a = 2'b10; alu_op = 2'b10; end
                S_EXECI:    begin alu_src_a = 2'b10; alu_src_b = 2'b01; alu_op = 2'b10; end
                S_ALUWB:    reg_write = 1'b1;
                S_BRANCH:   begin alu_src_a = 2'b10; alu_op = 2'b01; branch = 1'b1; end
                // ALUOut still holds the DECODE target while the ALU forms the link value.
                S_JAL:      begin alu_src_a = 2'b01; alu_src_b = 2'b10; pc_update = 1'b1; end
                S_JALR: begin
                    alu_src_a = 2'b10; alu_src_b = 2'b01; result_src = 2'b10; pc_update = 1'b1;
                end
                S_JALRWB: begin
                    alu_src_a = 2'b01; alu_src_b = 2'b10; result_src = 2'b10; reg_write = 1'b1;
                end
                S_UIMM: begin
                    alu_src_a = (bus.op == OP_LUI) ? 2'b11 : 2'b01;
                    alu_src_b = 2'b01; imm_src = 3'b100;
                end
                default: ;
            endcase
        end
    end

    assign bus.mem_req   = mem_req;
    assign bus.AdrSrc    = adr_src;
    assign bus.MemWrite  = mem_write;
    assign bus.IRWrite   = ir_write;
    assign bus.RegWrite  = reg_write;
    assign bus.PCWrite   = pc_update | (branch & taken);
    assign bus.ResultSrc = result_src;
    assign bus.ALUSrcA   = alu_src_a;
    assign bus.ALUSrcB   = alu_src_b;
    assign bus.ALUOp     = alu_op;
    assign bus.ImmSrc    = imm_src;
    assign bus.illegal   = reset && (state == S_DECODE) && !op_legal;
    assign bus.state_o   = state;

`ifdef MC_INSTRET_EN
    // DECODE only falls back to FETCH for an illegal opcode, which must not retire.
    logic retire;
    assign retire = (state != S_FETCH) && (state != S_DECODE) && (next_state == S_FETCH);

    always_ff @(posedge clk) begin
        if (!reset)      instret <= '0;
        else if (retire) instret <= instret + 32'd1;
    end
`endif

endmodule
